rv151_alu_arb: RTL and testbench
================================

// Module: rv151_alu_arb
// PURPOSE
//  Shares one rv151_alu instance between two requesters (r0: core execute, r1: CSR/debug unit).
//  Arbitrates, latches the winner's operands, drives the ALU, captures its result, returns it to the owner.
//  One op outstanding; fixed 3-cycle minimum turnaround.
//  The ALU is instantiated beside this block: alu_i1/alu_i2/alu_fn out, alu_ot back in.
// PARAMETERS
//  RR_EN   1  1: round-robin between r0/r1; 0: fixed priority, r0 always wins
// PORTS
//  clk          in   1   single clock, rising edge
//  rstn         in   1   asynchronous active-low reset
//  r0_req_valid in   1   r0 request valid
//  r0_req_ready out  1   r0 request accepted this cycle
//  r0_req_fn    in   4   r0 ALU function code (rv151_alu encoding)
//  r0_req_i1    in   32  r0 operand 1
//  r0_req_i2    in   32  r0 operand 2
//  r0_rsp_valid out  1   r0 result valid
//  r0_rsp_ready in   1   r0 result consumed
//  r0_rsp_data  out  32  r0 result
//  r1_*         --   --  identical set for requester r1
//  alu_i1       out  32  operand 1 to ALU (registered)
//  alu_i2       out  32  operand 2 to ALU (registered)
//  alu_fn       out  4   function to ALU (registered)
//  alu_ot       in   32  ALU combinational result
//  busy         out  1   1 whenever state != IDLE
// BEHAVIOUR
//  Reset (rstn=0, async): state=IDLE, last_gnt=1, every *_req_ready=0, every *_rsp_valid=0.
//   Also on reset: *_rsp_data=0, alu_i1/alu_i2=0, alu_fn=4'b0000, busy=0.
//  FSM states: IDLE -> EXEC -> RESP -> IDLE. No other transitions. Any state returns to IDLE on reset.
//  IDLE:
//   gnt0 = r0_req_valid & (!r1_req_valid | !RR_EN | last_gnt==1).
//   gnt1 = r1_req_valid & !gnt0.
//   rX_req_ready = gntX (combinational from valids; only ever asserted in IDLE).
//   On a grant: alu_i1/i2/fn <= winner payload; owner <= X; last_gnt <= X; go to EXEC.
//   No valid: stay in IDLE; ALU-side regs hold their values.
//  EXEC (1 cycle):
//   ALU evaluates the latched operands.
//   res <= alu_ot; go to RESP.
//   The 32-bit result is taken as-is (wrap-around from add/sub is not flagged).
//  RESP:
//   rX_rsp_valid=1 only for X==owner.
//   rX_rsp_data = res on both ports; it is valid only when the matching rsp_valid is 1.
//   Stay in RESP until rsp_ready from the owner; that cycle completes the op, go to IDLE.
//   A new request is not accepted in the completion cycle; the earliest next grant is the following cycle.
//  Latency: grant at cycle N -> rsp_valid high at N+2 -> back in IDLE at N+3 at the earliest.
//  Requester rules:
//   Hold req_valid and payload stable until req_ready.
//   req_valid may fall without a grant; that is legal and nothing is latched.
//  Responder rule: rsp_valid stays high and rsp_data stays stable until rsp_ready; backpressure may be unbounded.
//  Simultaneous requests with RR_EN=1 alternate grants. The first grant after reset goes to r0.
//  Non-owner rsp_ready is ignored. An unknown alu_fn is passed through unchanged; the ALU defaults it to ADD.
//  Reset mid-operation: the in-flight op is dropped and no response is issued; requesters must re-issue.
// TESTING
//  1. After reset: r0 ADD fn=0000 i1=5 i2=7, rsp_ready=1 -> r0_rsp_valid at grant+2, data=32'd12, busy low at grant+3.
//  2. r0 and r1 both valid, RR_EN=1: r0 SUB 10-3, r1 SLT -1<1 -> r0 gets 7 first, then r1 gets 1, then r0 again.
//  3. RR_EN=0, both requesters continuously valid -> r0 granted every op; r1_req_ready never 1.
//  4. r1 SRA fn=1101 i1=32'h8000_0000 i2=4 with rsp_ready=0 for 10 cycles:
//     -> rsp_valid and data=32'hF800_0000 held stable; r0 request stalled, not granted until 1 cycle after r1 completes.
//  5. Deassert rstn while in EXEC and again while in RESP -> all outputs at reset values immediately;
//     no rsp_valid after release; the next request is served normally.
//  6. r0 ADD 32'hFFFF_FFFF+1 -> rsp_data=0 (wrap). Also: pulse r1_req_valid for 1 cycle while busy -> never granted, no r1 rsp.

Source files
------------

// File: rtl/rv151_alu_arb.sv
// Two-requester arbiter sharing one rv151_alu: latches the winner's operands, captures the result, returns it to the owner.
// Latency: grant at N -> ALU evaluates at N+1 -> rsp_valid at N+2 -> IDLE at N+3 at the earliest.
// Backpressure: one op outstanding; RESP holds until the owner's rsp_ready, no new grant until back in IDLE.
module rv151_alu_arb #(
   parameter bit RR_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        r0_req_valid,
   output logic        r0_req_ready,
   input  logic [3:0]  r0_req_fn,
   input  logic [31:0] r0_req_i1,
   input  logic [31:0] r0_req_i2,
   output logic        r0_rsp_valid,
   input  logic        r0_rsp_ready,
   output logic [31:0] r0_rsp_data,
   input  logic        r1_req_valid,
   output logic        r1_req_ready,
   input  logic [3:0]  r1_req_fn,
   input  logic [31:0] r1_req_i1,
   input  logic [31:0] r1_req_i2,
   output logic        r1_rsp_valid,
   input  logic        r1_rsp_ready,
   output logic [31:0] r1_rsp_data,
   output logic [31:0] alu_i1,
   output logic [31:0] alu_i2,
   output logic [3:0]  alu_fn,
   input  logic [31:0] alu_ot,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state;
   logic        owner;      // requester that owns the in-flight op
   logic        last_gnt;   // most recent winner; resets to 1 so r0 wins the first tie
   logic [31:0] res;
   logic        gnt0;
   logic        gnt1;
   logic        own_rsp_ready;

   // Grants only exist in IDLE; r0 wins unless r1 is also asking and it is r1's turn
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state == IDLE) begin
         gnt0 = r0_req_valid & (~r1_req_valid | ~RR_EN | last_gnt);
         gnt1 = r1_req_valid & ~gnt0;
      end
   end

   assign r0_req_ready  = gnt0;
   assign r1_req_ready  = gnt1;
   assign own_rsp_ready = owner ? r1_rsp_ready : r0_rsp_ready;

   // Result is presented on both ports; only the owner's valid qualifies it
   assign r0_rsp_data = res;
   assign r1_rsp_data = res;

   // Operation sequencer with registered ALU-side and response-side outputs
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= IDLE;
         owner        <= 1'b0;
         last_gnt     <= 1'b1;
         alu_i1       <= 32'd0;
         alu_i2       <= 32'd0;
         alu_fn       <= 4'b0000;
         res          <= 32'd0;
         r0_rsp_valid <= 1'b0;
         r1_rsp_valid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt0) begin
                  alu_i1   <= r0_req_i1;
                  alu_i2   <= r0_req_i2;
                  alu_fn   <= r0_req_fn;
                  owner    <= 1'b0;
                  last_gnt <= 1'b0;
                  busy     <= 1'b1;
                  state    <= EXEC;
               end else if (gnt1) begin
                  alu_i1   <= r1_req_i1;
                  alu_i2   <= r1_req_i2;
                  alu_fn   <= r1_req_fn;
                  owner    <= 1'b1;
                  last_gnt <= 1'b1;
                  busy     <= 1'b1;
                  state    <= EXEC;
               end
            end
            EXEC: begin
               // Full 32-bit result kept as-is; arithmetic wrap is not flagged
               res          <= alu_ot;
               r0_rsp_valid <= ~owner;
               r1_rsp_valid <= owner;
               state        <= RESP;
            end
            RESP: begin
               // Only the owner's handshake completes the op; IDLE is re-entered next cycle
               if (own_rsp_ready) begin
                  r0_rsp_valid <= 1'b0;
                  r1_rsp_valid <= 1'b0;
                  busy         <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: begin
               r0_rsp_valid <= 1'b0;
               r1_rsp_valid <= 1'b0;
               busy         <= 1'b0;
               state        <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rv151_alu_arb.sv
// Bench for rv151_alu_arb: round-robin instance plus a fixed-priority instance, each with a behavioural ALU.
// Reference: ALU results from plain arithmetic, grant order from the alternation rule, timing from grant+2/grant+3.
// All outputs sampled on the falling edge; inputs driven right after sampling.
module tb_rv151_alu_arb;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rstn;

   // round-robin instance
   logic        r0_req_valid, r0_req_ready, r0_rsp_valid, r0_rsp_ready;
   logic [3:0]  r0_req_fn;
   logic [31:0] r0_req_i1, r0_req_i2, r0_rsp_data;
   logic        r1_req_valid, r1_req_ready, r1_rsp_valid, r1_rsp_ready;
   logic [3:0]  r1_req_fn;
   logic [31:0] r1_req_i1, r1_req_i2, r1_rsp_data;
   logic [31:0] alu_i1, alu_i2, alu_ot;
   logic [3:0]  alu_fn;
   logic        busy;

   // fixed-priority instance
   logic        f_r0_req_valid, f_r0_req_ready, f_r0_rsp_valid, f_r0_rsp_ready;
   logic [3:0]  f_r0_req_fn;
   logic [31:0] f_r0_req_i1, f_r0_req_i2, f_r0_rsp_data;
   logic        f_r1_req_valid, f_r1_req_ready, f_r1_rsp_valid, f_r1_rsp_ready;
   logic [3:0]  f_r1_req_fn;
   logic [31:0] f_r1_req_i1, f_r1_req_i2, f_r1_rsp_data;
   logic [31:0] f_alu_i1, f_alu_i2, f_alu_ot;
   logic [3:0]  f_alu_fn;
   logic        f_busy;

   int total = 0;
   int bad   = 0;
   int model_last;                 // last granted requester per the alternation rule
   logic [3:0]  oth_fn;            // payload used by the other requester in interference scenarios
   logic [31:0] oth_a, oth_b;
   logic [3:0]  fns [10] = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                             4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};

   // behavioural rv151_alu: {funct7[5], funct3} encoding, unknown codes act as ADD
   function automatic logic [31:0] alu_ref(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
      case (fn)
         4'b1000: return a - b;
         4'b0001: return a << b[4:0];
         4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b0011: return (a < b) ? 32'd1 : 32'd0;
         4'b0100: return a ^ b;
         4'b0101: return a >> b[4:0];
         4'b1101: return $unsigned($signed(a) >>> b[4:0]);
         4'b0110: return a | b;
         4'b0111: return a & b;
         default: return a + b;
      endcase
   endfunction

   assign alu_ot   = alu_ref(alu_fn, alu_i1, alu_i2);
   assign f_alu_ot = alu_ref(f_alu_fn, f_alu_i1, f_alu_i2);

   rv151_alu_arb #(.RR_EN(1'b1)) u_rr (
      .clk(clk), .rstn(rstn),
      .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_req_fn(r0_req_fn),
      .r0_req_i1(r0_req_i1), .r0_req_i2(r0_req_i2),
      .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready), .r0_rsp_data(r0_rsp_data),
      .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_req_fn(r1_req_fn),
      .r1_req_i1(r1_req_i1), .r1_req_i2(r1_req_i2),
      .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready), .r1_rsp_data(r1_rsp_data),
      .alu_i1(alu_i1), .alu_i2(alu_i2), .alu_fn(alu_fn), .alu_ot(alu_ot), .busy(busy)
   );

   rv151_alu_arb #(.RR_EN(1'b0)) u_fix (
      .clk(clk), .rstn(rstn),
      .r0_req_valid(f_r0_req_valid), .r0_req_ready(f_r0_req_ready), .r0_req_fn(f_r0_req_fn),
      .r0_req_i1(f_r0_req_i1), .r0_req_i2(f_r0_req_i2),
      .r0_rsp_valid(f_r0_rsp_valid), .r0_rsp_ready(f_r0_rsp_ready), .r0_rsp_data(f_r0_rsp_data),
      .r1_req_valid(f_r1_req_valid), .r1_req_ready(f_r1_req_ready), .r1_req_fn(f_r1_req_fn),
      .r1_req_i1(f_r1_req_i1), .r1_req_i2(f_r1_req_i2),
      .r1_rsp_valid(f_r1_rsp_valid), .r1_rsp_ready(f_r1_rsp_ready), .r1_rsp_data(f_r1_rsp_data),
      .alu_i1(f_alu_i1), .alu_i2(f_alu_i2), .alu_fn(f_alu_fn), .alu_ot(f_alu_ot), .busy(f_busy)
   );

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_req(input int x, input logic v, input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
      if (x == 0) begin
         r0_req_valid = v; r0_req_fn = fn; r0_req_i1 = a; r0_req_i2 = b;
      end else begin
         r1_req_valid = v; r1_req_fn = fn; r1_req_i1 = a; r1_req_i2 = b;
      end
   endtask

   task automatic set_rsp_rdy(input int x, input logic v);
      if (x == 0) r0_rsp_ready = v;
      else        r1_rsp_ready = v;
   endtask

   function automatic logic req_rdy(input int x);
      return (x == 0) ? r0_req_ready : r1_req_ready;
   endfunction

   function automatic logic rsp_vld(input int x);
      return (x == 0) ? r0_rsp_valid : r1_rsp_valid;
   endfunction

   function automatic logic [31:0] rsp_dat(input int x);
      return (x == 0) ? r0_rsp_data : r1_rsp_data;
   endfunction

   // One op on the round-robin instance. mode 1: other requester raises a request at grant+1 and holds it;
   // mode 2: other requester pulses valid for one cycle at grant+1.
   task automatic run_op(input int x, input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b,
                         input int stall, input int mode, output int waited);
      int y = 1 - x;
      logic [31:0] exp = alu_ref(fn, a, b);
      drive_req(x, 1'b1, fn, a, b);
      #1;
      waited = 0;
      while (!req_rdy(x) && waited < 20) begin
         tick(); waited++;
      end
      total++;
      if (!req_rdy(x)) begin
         bad++; $display("FAIL grant_timeout r%0d got=0 exp=1", x);
         drive_req(x, 1'b0, fn, a, b);
         return;
      end
      model_last = x;
      tick();                                   // grant+1: EXEC
      drive_req(x, 1'b0, fn, a, b);
      if (mode != 0) drive_req(y, 1'b1, oth_fn, oth_a, oth_b);
      #1;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL exec_busy got=%b exp=1", busy); end
      total++; if (alu_fn !== fn) begin bad++; $display("FAIL exec_alu_fn got=%h exp=%h", alu_fn, fn); end
      total++; if (alu_i1 !== a) begin bad++; $display("FAIL exec_alu_i1 got=%h exp=%h", alu_i1, a); end
      total++; if (alu_i2 !== b) begin bad++; $display("FAIL exec_alu_i2 got=%h exp=%h", alu_i2, b); end
      total++; if (rsp_vld(x) !== 1'b0) begin bad++; $display("FAIL exec_rsp_early got=%b exp=0", rsp_vld(x)); end
      total++; if (req_rdy(y) !== 1'b0) begin bad++; $display("FAIL exec_other_ready got=%b exp=0", req_rdy(y)); end
      tick();                                   // grant+2: RESP
      if (mode == 2) drive_req(y, 1'b0, oth_fn, oth_a, oth_b);
      total++; if (rsp_vld(x) !== 1'b1) begin bad++; $display("FAIL rsp_valid r%0d got=%b exp=1", x, rsp_vld(x)); end
      total++; if (rsp_dat(x) !== exp) begin bad++; $display("FAIL rsp_data r%0d got=%h exp=%h", x, rsp_dat(x), exp); end
      total++; if (rsp_vld(y) !== 1'b0) begin bad++; $display("FAIL rsp_nonowner got=%b exp=0", rsp_vld(y)); end
      if (stall > 0) set_rsp_rdy(y, 1'b1);      // non-owner handshake must be ignored
      for (int i = 0; i < stall; i++) begin
         tick();
         total++;
         if (rsp_vld(x) !== 1'b1 || rsp_dat(x) !== exp || busy !== 1'b1)
            begin bad++; $display("FAIL rsp_hold got=%b/%h exp=1/%h", rsp_vld(x), rsp_dat(x), exp); end
         if (mode == 1) begin
            total++; if (req_rdy(y) !== 1'b0) begin bad++; $display("FAIL stall_other_ready got=1 exp=0"); end
         end
      end
      if (mode == 1) begin
         total++; if (req_rdy(y) !== 1'b0) begin bad++; $display("FAIL completion_cycle_grant got=1 exp=0"); end
      end
      set_rsp_rdy(x, 1'b1);
      tick();                                   // first cycle after completion
      set_rsp_rdy(x, 1'b0);
      set_rsp_rdy(y, 1'b0);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
      total++; if (rsp_vld(x) !== 1'b0) begin bad++; $display("FAIL rsp_drop got=%b exp=0", rsp_vld(x)); end
      if (mode == 1) begin
         total++; if (req_rdy(y) !== 1'b1) begin bad++; $display("FAIL next_grant got=%b exp=1", req_rdy(y)); end
      end
   endtask

   task automatic test_reset();
      total++; if (busy !== 1'b0 || f_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b%b exp=00", busy, f_busy); end
      total++; if (r0_rsp_valid !== 1'b0 || r1_rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b%b exp=00", r0_rsp_valid, r1_rsp_valid); end
      total++; if (r0_req_ready !== 1'b0 || r1_req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%b%b exp=00", r0_req_ready, r1_req_ready); end
      total++; if (alu_i1 !== 32'd0 || alu_i2 !== 32'd0) begin bad++; $display("FAIL reset_alu_ops got=%h/%h exp=0/0", alu_i1, alu_i2); end
      total++; if (alu_fn !== 4'b0000) begin bad++; $display("FAIL reset_alu_fn got=%h exp=0", alu_fn); end
      total++; if (r0_rsp_data !== 32'd0 || r1_rsp_data !== 32'd0) begin bad++; $display("FAIL reset_rsp_data got=%h/%h exp=0/0", r0_rsp_data, r1_rsp_data); end
   endtask

   task automatic test_basic_add();
      int w;
      run_op(0, 4'b0000, 32'd5, 32'd7, 0, 0, w);
      total++; if (r0_rsp_data !== 32'd12) begin bad++; $display("FAIL add_5_7 got=%h exp=0000000c", r0_rsp_data); end
   endtask

   task automatic test_round_robin();
      logic [3:0]  fn0, fn1;
      logic [31:0] a0, b0, a1, b1, exp;
      int exp_w, w, n;
      rstn = 1'b0; #1; rstn = 1'b1;
      model_last = 1;
      fn0 = 4'b1000; a0 = 32'd10; b0 = 32'd3;
      fn1 = 4'b0010; a1 = 32'hFFFF_FFFF; b1 = 32'd1;
      r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         drive_req(0, 1'b1, fn0, a0, b0);
         drive_req(1, 1'b1, fn1, a1, b1);
         #1;
         n = 0;
         while (!(r0_req_ready || r1_req_ready) && n < 20) begin tick(); n++; end
         exp_w = (model_last == 1) ? 0 : 1;
         total++;
         if (r0_req_ready !== (exp_w == 0) || r1_req_ready !== (exp_w == 1)) begin
            bad++; $display("FAIL rr_winner op%0d got=%b%b exp_r%0d", k, r1_req_ready, r0_req_ready, exp_w);
         end
         w = r1_req_ready ? 1 : 0;
         exp = (w == 0) ? alu_ref(fn0, a0, b0) : alu_ref(fn1, a1, b1);
         model_last = exp_w;
         tick();
         if (w == 0) begin fn0 = fns[$urandom_range(9)]; a0 = $urandom; b0 = $urandom; end
         else        begin fn1 = fns[$urandom_range(9)]; a1 = $urandom; b1 = $urandom; end
         tick();
         total++;
         if (rsp_vld(w) !== 1'b1 || rsp_dat(w) !== exp) begin
            bad++; $display("FAIL rr_rsp op%0d got=%b/%h exp=1/%h", k, rsp_vld(w), rsp_dat(w), exp);
         end
         if (k == 0) begin total++; if (r0_rsp_data !== 32'd7) begin bad++; $display("FAIL rr_first_sub got=%h exp=7", r0_rsp_data); end end
         if (k == 1) begin total++; if (r1_rsp_data !== 32'd1) begin bad++; $display("FAIL rr_second_slt got=%h exp=1", r1_rsp_data); end end
         tick();
      end
      drive_req(0, 1'b0, fn0, a0, b0);
      drive_req(1, 1'b0, fn1, a1, b1);
      tick(); tick(); tick();
      r0_rsp_ready = 1'b0; r1_rsp_ready = 1'b0;
      tick();
   endtask

   task automatic test_fixed_priority();
      int grants = 0;
      int r1_seen = 0;
      logic grabbed;
      logic [31:0] exp = 32'd0;
      f_r0_rsp_ready = 1'b1; f_r1_rsp_ready = 1'b1;
      f_r0_req_fn = fns[$urandom_range(9)]; f_r0_req_i1 = $urandom; f_r0_req_i2 = $urandom;
      f_r1_req_fn = 4'b0000; f_r1_req_i1 = 32'd1; f_r1_req_i2 = 32'd2;
      f_r0_req_valid = 1'b1; f_r1_req_valid = 1'b1;
      #1;
      for (int c = 0; c < 30; c++) begin
         grabbed = 1'b0;
         if (f_r1_req_ready || f_r1_rsp_valid) r1_seen++;
         if (f_r0_req_ready) begin
            grants++; grabbed = 1'b1;
            exp = alu_ref(f_r0_req_fn, f_r0_req_i1, f_r0_req_i2);
         end
         if (f_r0_rsp_valid) begin
            total++;
            if (f_r0_rsp_data !== exp) begin bad++; $display("FAIL fix_rsp_data got=%h exp=%h", f_r0_rsp_data, exp); end
         end
         tick();
         if (grabbed) begin
            f_r0_req_fn = fns[$urandom_range(9)]; f_r0_req_i1 = $urandom; f_r0_req_i2 = $urandom;
         end
      end
      total++; if (r1_seen != 0) begin bad++; $display("FAIL fix_r1_granted got=%0d exp=0", r1_seen); end
      total++; if (grants != 10) begin bad++; $display("FAIL fix_grant_count got=%0d exp=10", grants); end
      f_r0_req_valid = 1'b0; f_r1_req_valid = 1'b0;
      tick(); tick(); tick();
      f_r0_rsp_ready = 1'b0; f_r1_rsp_ready = 1'b0;
   endtask

   task automatic test_backpressure_sra();
      int w;
      oth_fn = 4'b0100; oth_a = 32'h1234_5678; oth_b = 32'h0F0F_0F0F;
      run_op(1, 4'b1101, 32'h8000_0000, 32'd4, 10, 1, w);
      total++; if (r1_rsp_data !== 32'hF800_0000) begin bad++; $display("FAIL sra_data got=%h exp=f8000000", r1_rsp_data); end
      run_op(0, oth_fn, oth_a, oth_b, 0, 0, w);
      total++; if (w != 0) begin bad++; $display("FAIL stalled_r0_wait got=%0d exp=0", w); end
   endtask

   task automatic test_reset_mid_op();
      int n, w;
      for (int k = 0; k < 2; k++) begin
         drive_req(0, 1'b1, 4'b0000, 32'd100, 32'd23);
         #1;
         n = 0;
         while (!r0_req_ready && n < 20) begin tick(); n++; end
         tick();
         drive_req(0, 1'b0, 4'b0000, 32'd0, 32'd0);
         if (k == 1) tick();
         #2 rstn = 1'b0;
         #1;
         total++;
         if (busy !== 1'b0 || r0_rsp_valid !== 1'b0 || r0_rsp_data !== 32'd0 || alu_i1 !== 32'd0 || alu_fn !== 4'b0000)
            begin bad++; $display("FAIL midop_reset%0d got=%b%b/%h/%h exp=00/0/0", k, busy, r0_rsp_valid, r0_rsp_data, alu_i1); end
         @(negedge clk);
         rstn = 1'b1;
         model_last = 1;
         r0_rsp_ready = 1'b1;
         for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if (r0_rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL midop_ghost%0d got=%b%b exp=00", k, r0_rsp_valid, busy); end
         end
         r0_rsp_ready = 1'b0;
         run_op(0, 4'b0111, 32'hF0F0_1234, 32'h0FF0_FFFF, 1, 0, w);
      end
   endtask

   task automatic test_wrap_and_pulse();
      int w;
      run_op(0, 4'b0000, 32'hFFFF_FFFF, 32'd1, 0, 0, w);
      total++; if (r0_rsp_data !== 32'd0) begin bad++; $display("FAIL add_wrap got=%h exp=0", r0_rsp_data); end
      oth_fn = 4'b0110; oth_a = 32'hAAAA_0000; oth_b = 32'h0000_5555;
      run_op(0, 4'b1010, 32'd40, 32'd2, 2, 2, w);  // unknown fn also rides along
      for (int c = 0; c < 4; c++) begin
         tick();
         total++;
         if (busy !== 1'b0 || r1_rsp_valid !== 1'b0) begin bad++; $display("FAIL pulse_granted got=%b%b exp=00", busy, r1_rsp_valid); end
      end
   endtask

   task automatic test_random();
      int w, x;
      logic [3:0] fn;
      for (int k = 0; k < 20; k++) begin
         x  = $urandom_range(1);
         fn = ($urandom_range(3) == 0) ? 4'($urandom) : fns[$urandom_range(9)];
         run_op(x, fn, $urandom, $urandom, $urandom_range(3), 0, w);
      end
   endtask

   initial begin
      rstn = 1'b0;
      drive_req(0, 1'b0, 4'b0000, 32'd0, 32'd0);
      drive_req(1, 1'b0, 4'b0000, 32'd0, 32'd0);
      r0_rsp_ready = 1'b0; r1_rsp_ready = 1'b0;
      f_r0_req_valid = 1'b0; f_r0_req_fn = 4'b0; f_r0_req_i1 = 32'd0; f_r0_req_i2 = 32'd0; f_r0_rsp_ready = 1'b0;
      f_r1_req_valid = 1'b0; f_r1_req_fn = 4'b0; f_r1_req_i1 = 32'd0; f_r1_req_i2 = 32'd0; f_r1_rsp_ready = 1'b0;
      oth_fn = 4'b0; oth_a = 32'd0; oth_b = 32'd0;
      model_last = 1;
      @(negedge clk); @(negedge clk);
      test_reset();
      rstn = 1'b1;
      tick();
      test_basic_add();
      test_round_robin();
      test_fixed_priority();
      test_backpressure_sra();
      test_reset_mid_op();
      test_wrap_and_pulse();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
